fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage: produces the inst/pc pair consumed by the fetch/decode pipeline register.
//  Generates sequential PCs, issues in-order requests to instruction memory over a valid/ready
//  request channel with variable-latency responses, and buffers returned instructions.
//  Honours the same stall signal as the F/D register. Takes branch/jump redirects from execute,
//  which flush all buffered and in-flight fetches.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  2              instruction buffer entries; also the max in-flight + buffered total (>=1)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   reset, asynchronous, active-low
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  fetch address, word aligned
//  imem_resp_valid in   1   response data valid; responses in request order, >=1 cycle after accept
//  imem_resp_data  in   32  instruction word
//  stall           in   1   1 = F/D holds; do not pop buffer head
//  redirect_valid  in   1   control-flow redirect (taken branch/jump)
//  redirect_pc     in   32  redirect target, word aligned
//  inst            out  32  instruction to F/D register
//  pc              out  32  pc of inst
//  inst_valid      out  1   1 = inst/pc is a real fetched instruction, 0 = bubble
// BEHAVIOUR
//  State:
//   - fetch_pc: next request address
//   - resp_pc: pc of the oldest live in-flight request
//   - O: in-flight count; K: in-flight responses to discard (K<=O)
//   - buffer of FIFO_DEPTH {inst,pc} entries, occupancy C
//  Reset (rst=0, async):
//   - fetch_pc=resp_pc=RESET_PC; O=K=C=0; imem_req_valid=0
//   - inst=32'h0000_0013 (NOP), pc=0, inst_valid=0
//   - in-flight requests are forgotten; memory is reset by the same rst
//  Request channel:
//   - imem_req_valid = (O+C < FIFO_DEPTH) && !redirect_valid
//   - imem_req_addr = fetch_pc
//   - Accept when valid&&ready: fetch_pc += 4 (32-bit wrap), O += 1
//   - While valid && !ready: addr held stable
//  Response:
//   - on imem_resp_valid: O -= 1
//   - if K>0 or redirect_valid this cycle: discard word, K -= 1 if K>0
//   - else: push {data, resp_pc}, resp_pc += 4
//   - Credit rule guarantees the push never overflows; overflow is an assertion failure
//  Output:
//   - combinational from buffer head: C>0 -> inst/pc = head, inst_valid=1
//   - C==0 -> inst=NOP 32'h0000_0013, pc=resp_pc, inst_valid=0
//  Pop:
//   - when !stall && C>0 && !redirect_valid
//   - with stall=1, head and outputs are unchanged
//  Simultaneous push and pop: C unchanged. Credit uses registered O/C; no same-cycle bypass.
//  Redirect (highest priority, one cycle):
//   - C <= 0
//   - fetch_pc <= redirect_pc; resp_pc <= redirect_pc
//   - K <= O_next, i.e. every in-flight request after this cycle's accept/response
//   - no request is issued in the redirect cycle
//   - redirect overrides stall
//  Latency: redirect -> first request at redirect_pc the next cycle.
//   Memory returning at 1 cycle: fetched inst valid at output 2 cycles after the request is accepted.
//  Steady state: one instruction per cycle requires FIFO_DEPTH >= memory latency + 1.
// TESTING
//  1. RESET_PC=0x100, ready=1, 1-cycle memory, stall=0
//     -> req addrs 0x100,0x104,0x108...; outputs pc 0x100,0x104 in order, inst_valid=1
//  2. stall=1 for 4 cycles mid-stream
//     -> head pc constant; req_valid drops when O+C=2
//     -> after release, pcs continue with no gap or duplicate
//  3. Redirect to 0x200 with O=2
//     -> both late responses dropped; next req addr 0x200; first valid output pc=0x200
//  4. Memory latency 5 cycles
//     -> inst=0x00000013, inst_valid=0 while the buffer is empty; no request beyond 2 outstanding
//  5. imem_req_ready=0 for 3 cycles
//     -> req_valid=1 and addr stable; accepted exactly once
//  6. rst pulsed low mid-stream
//     -> outputs NOP/0/0 immediately; next request at RESET_PC after release
//  7. Redirect, response and stall in the same cycle
//     -> response discarded, buffer empty, fetch_pc=redirect_pc

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited in-order imem requests,
// response buffering, stall-aware output and redirect flush of buffered/in-flight fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  imem,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   inst,
  output logic [31:0]   pc,
  output logic          inst_valid
);

  localparam int unsigned   CW      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned   PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(FIFO_DEPTH - 1);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] o_cnt, k_cnt, c_cnt, o_next;
  logic [PW-1:0] head, tail;
  logic [31:0]   buf_inst [FIFO_DEPTH];
  logic [31:0]   buf_pc   [FIFO_DEPTH];
  logic          accept, discard, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Credit counts in-flight plus buffered entries, so a response always has a free slot.
  assign imem.imem_req_valid = rst && (({1'b0, o_cnt} + {1'b0, c_cnt}) < DEPTH_W) && !redirect_valid;
  assign imem.imem_req_addr  = fetch_pc;

  always_comb begin
    accept  = imem.imem_req_valid && imem.imem_req_ready;
    discard = imem.imem_resp_valid && ((k_cnt != '0) || redirect_valid);
    push    = imem.imem_resp_valid && !discard;
    pop     = !stall && (c_cnt != '0) && !redirect_valid;
    o_next  = o_cnt + CW'(accept) - CW'(imem.imem_resp_valid);
  end

  // Held in reset the outputs read as a bubble with pc 0, independent of RESET_PC.
  always_comb begin
    inst       = NOP;
    pc         = '0;
    inst_valid = 1'b0;
    if (rst) begin
      if (c_cnt != '0) begin
        inst       = buf_inst[head];
        pc         = buf_pc[head];
        inst_valid = 1'b1;
      end else begin
        pc = resp_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[tail] <= imem.imem_resp_data;
      buf_pc[tail]   <= resp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      o_cnt    <= '0;
      k_cnt    <= '0;
      c_cnt    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect_valid) begin
      // Every request still outstanding after this edge belongs to the squashed path.
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
      o_cnt    <= o_next;
      k_cnt    <= o_next;
      c_cnt    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      o_cnt <= o_next;
      if (imem.imem_resp_valid && (k_cnt != '0)) k_cnt <= k_cnt - CW'(1);
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        tail    <= nxt(tail);
      end
      if (pop) head <= nxt(head);
      c_cnt <= c_cnt + CW'(push) - CW'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (c_cnt == DEPTH_C)));

endmodule
